// File: rtl/absorb_block_padder_if.sv
// Message-in / block-out bus between the message source, the padder and the absorb stage.
interface absorb_block_padder_if #(
  parameter int unsigned BWIDTH    = 32,
  parameter int unsigned NUMBLOCKS = 4
);
  localparam int unsigned BYTES_W = $clog2(BWIDTH / 8) + 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [BWIDTH-1:0]             in_data;
  logic [BYTES_W-1:0]            in_bytes;
  logic                          in_last;
  logic [1:0]                    in_domain;
  logic                          out_valid;
  logic                          out_ready;
  logic [BWIDTH*NUMBLOCKS-1:0]   blocks;
  logic                          padded;
  logic                          finalize;
  logic [1:0]                    domain;

  modport master (
    output in_valid, in_data, in_bytes, in_last, in_domain, out_ready,
    input  in_ready, out_valid, blocks, padded, finalize, domain
  );

  modport slave (
    input  in_valid, in_data, in_bytes, in_last, in_domain, out_ready,
    output in_ready, out_valid, blocks, padded, finalize, domain
  );
endinterface

// File: rtl/absorb_block_padder.sv
// Packs byte-granular message words into rate blocks with 10* byte padding
// and hands them to the sponge absorb stage over a valid/ready handshake.
module absorb_block_padder #(
  parameter int unsigned BWIDTH    = 32,
  parameter int unsigned NUMBLOCKS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  absorb_block_padder_if.slave  bus
);
  localparam int unsigned NB      = BWIDTH / 8;
  localparam int unsigned BYTES_W = $clog2(NB) + 1;
  localparam int unsigned WCW     = (NUMBLOCKS > 1) ? $clog2(NUMBLOCKS) : 1;
  localparam int unsigned BLKW    = BWIDTH * NUMBLOCKS;

  localparam logic [BYTES_W-1:0] NB_B    = BYTES_W'(NB);
  localparam logic [WCW-1:0]     WLAST   = WCW'(NUMBLOCKS - 1);
  localparam logic [BLKW-1:0]    PAD_BLK = BLKW'(8'h01);

  typedef enum logic [1:0] {FILL, EMIT, PADBLK} state_e;

  state_e            state_q;
  logic [WCW-1:0]    wcnt_q;
  logic [BLKW-1:0]   buf_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              padded_q;
  logic              finalize_q;
  logic              pend_q;
  logic              first_q;
  logic [1:0]        domain_q;

  logic              accept;
  logic [BYTES_W-1:0] bytes_eff;
  logic              partial;
  logic              last_eff;
  logic              full_last;
  logic              wrap;
  logic [BWIDTH-1:0] word_d;
  logic [BLKW-1:0]   buf_d;

  always_comb begin
    accept    = bus.in_valid & in_ready_q;
    bytes_eff = (bus.in_bytes > NB_B) ? NB_B : bus.in_bytes;
    partial   = (bytes_eff != NB_B);
    last_eff  = bus.in_last | partial;
    full_last = last_eff & ~partial;
    wrap      = (wcnt_q == WLAST);

    // Bytes past the valid count are zeroed; a short word carries its own pad byte.
    word_d = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      if (j < 32'(bytes_eff))
        word_d[j*8 +: 8] = bus.in_data[j*8 +: 8];
      else if (j == 32'(bytes_eff))
        word_d[j*8 +: 8] = 8'h01;
    end

    buf_d = buf_q;
    for (int unsigned k = 0; k < NUMBLOCKS; k++) begin
      if (k == 32'(wcnt_q))
        buf_d[k*BWIDTH +: BWIDTH] = word_d;
      else if (full_last && !wrap && (k == 32'(wcnt_q) + 1))
        buf_d[k*BWIDTH +: BWIDTH] = BWIDTH'(8'h01);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      wcnt_q      <= '0;
      buf_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      padded_q    <= 1'b0;
      finalize_q  <= 1'b0;
      pend_q      <= 1'b0;
      first_q     <= 1'b1;
      domain_q    <= '0;
    end else begin
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            buf_q   <= buf_d;
            first_q <= last_eff;
            if (first_q)
              domain_q <= bus.in_domain;
            if (last_eff || wrap) begin
              // A full final word in the last slot leaves no room for the pad byte,
              // so that block goes out unpadded and a pad-only block follows.
              state_q     <= EMIT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              padded_q    <= last_eff & (partial | ~wrap);
              finalize_q  <= last_eff & (partial | ~wrap);
              pend_q      <= full_last & wrap;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            wcnt_q <= '0;
            if (pend_q) begin
              state_q    <= PADBLK;
              buf_q      <= PAD_BLK;
              padded_q   <= 1'b1;
              finalize_q <= 1'b1;
              pend_q     <= 1'b0;
            end else begin
              state_q     <= FILL;
              buf_q       <= '0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              padded_q    <= 1'b0;
              finalize_q  <= 1'b0;
            end
          end
        end
        PADBLK: begin
          if (bus.out_ready) begin
            state_q     <= FILL;
            buf_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            padded_q    <= 1'b0;
            finalize_q  <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.blocks    = buf_q;
  assign bus.padded    = padded_q;
  assign bus.finalize  = finalize_q;
  assign bus.domain    = domain_q;
endmodule

// File: tb/tb_absorb_block_padder.sv
// Directed bench for absorb_block_padder (BWIDTH=32, NUMBLOCKS=4) with an expected-block scoreboard.
module tb_absorb_block_padder;
  logic clk;
  logic reset;

  absorb_block_padder_if #(.BWIDTH(32), .NUMBLOCKS(4)) ifc ();

  absorb_block_padder #(.BWIDTH(32), .NUMBLOCKS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] blk;
    logic         p;
    logic         f;
    logic [1:0]   d;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic push(input logic [127:0] b, input logic p, input logic f, input logic [1:0] d);
    exp_t e;
    e.blk = b; e.p = p; e.f = f; e.d = d;
    sb.push_back(e);
  endtask

  task automatic check_block();
    exp_t e;
    if (sb.size() == 0) begin
      fail_now("sb_unexpected_block");
    end else begin
      e = sb.pop_front();
      chk("blocks",   ifc.blocks,   e.blk);
      chk("padded",   ifc.padded,   e.p);
      chk("finalize", ifc.finalize, e.f);
      chk("domain",   ifc.domain,   e.d);
      chk("in_ready_during_out", ifc.in_ready, 1'b0);
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
  endtask

  task automatic wait_block();
    int unsigned n = 0;
    while (ifc.out_valid !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        fail_now("wait_block_timeout");
        return;
      end
    end
    check_block();
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [2:0] b, input logic l, input logic [1:0] dm);
    int unsigned n = 0;
    while (ifc.in_ready !== 1'b1) begin
      if (ifc.out_valid === 1'b1) check_block();
      else @(negedge clk);
      n++;
      if (n > 20) begin
        fail_now("send_timeout");
        return;
      end
    end
    ifc.in_valid  = 1'b1;
    ifc.in_data   = d;
    ifc.in_bytes  = b;
    ifc.in_last   = l;
    ifc.in_domain = dm;
    @(negedge clk);
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
  endtask

  initial begin
    exp_t held;
    reset         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_bytes  = '0;
    ifc.in_last   = 1'b0;
    ifc.in_domain = '0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", ifc.out_valid, 1'b0);
    chk("rst_blocks",    ifc.blocks,    '0);
    chk("rst_padded",    ifc.padded,    1'b0);
    chk("rst_finalize",  ifc.finalize,  1'b0);
    chk("rst_domain",    ifc.domain,    2'd0);
    chk("rst_in_ready",  ifc.in_ready,  1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", ifc.in_ready, 1'b1);

    // Reset in the middle of a message discards it
    send_beat(32'h11111111, 3'd4, 1'b0, 2'd1);
    send_beat(32'h22222222, 3'd4, 1'b0, 2'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", ifc.out_valid, 1'b0);
    chk("midrst_blocks",    ifc.blocks,    '0);
    chk("midrst_in_ready",  ifc.in_ready,  1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_back", ifc.in_ready, 1'b1);

    // Three words, short last word; domain taken from the first beat only
    push({32'h0, 32'h0001BBAA, 32'h07060504, 32'h03020100}, 1'b1, 1'b1, 2'd2);
    send_beat(32'h03020100, 3'd4, 1'b0, 2'd2);
    send_beat(32'h07060504, 3'd4, 1'b0, 2'd3);
    send_beat(32'hDDCCBBAA, 3'd2, 1'b1, 2'd3);
    chk("t2_latency_valid", ifc.out_valid, 1'b1);
    wait_block();

    // Four full words: unpadded block then a pad-only block
    push({32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, 1'b0, 1'b0, 2'd1);
    push({96'h0, 32'h00000001}, 1'b1, 1'b1, 2'd1);
    send_beat(32'hA0A0A0A0, 3'd4, 1'b0, 2'd1);
    send_beat(32'hA1A1A1A1, 3'd4, 1'b0, 2'd0);
    send_beat(32'hA2A2A2A2, 3'd4, 1'b0, 2'd0);
    send_beat(32'hA3A3A3A3, 3'd4, 1'b1, 2'd0);
    wait_block();
    wait_block();

    // Empty message
    push({96'h0, 32'h00000001}, 1'b1, 1'b1, 2'd3);
    send_beat(32'hFFFFFFFF, 3'd0, 1'b1, 2'd3);
    wait_block();

    // Six full words, the last flagged: second block padded in word 2
    push({32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0}, 1'b0, 1'b0, 2'd2);
    push({32'h0, 32'h00000001, 32'hB5B5B5B5, 32'hB4B4B4B4}, 1'b1, 1'b1, 2'd2);
    send_beat(32'hB0B0B0B0, 3'd4, 1'b0, 2'd2);
    send_beat(32'hB1B1B1B1, 3'd4, 1'b0, 2'd1);
    send_beat(32'hB2B2B2B2, 3'd4, 1'b0, 2'd1);
    send_beat(32'hB3B3B3B3, 3'd4, 1'b0, 2'd1);
    send_beat(32'hB4B4B4B4, 3'd4, 1'b0, 2'd1);
    send_beat(32'hB5B5B5B5, 3'd4, 1'b1, 2'd1);
    wait_block();

    // Backpressure: outputs stay stable while out_ready is low
    push({96'h0, 32'h01B2C3D4}, 1'b1, 1'b1, 2'd2);
    send_beat(32'hA1B2C3D4, 3'd3, 1'b1, 2'd2);
    held = sb[0];
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", ifc.out_valid, 1'b1);
      chk("stall_blocks",    ifc.blocks,    held.blk);
      chk("stall_padded",    ifc.padded,    held.p);
      chk("stall_domain",    ifc.domain,    held.d);
      chk("stall_in_ready",  ifc.in_ready,  1'b0);
      @(negedge clk);
    end
    check_block();
    chk("stall_release_in_ready",  ifc.in_ready,  1'b1);
    chk("stall_release_out_valid", ifc.out_valid, 1'b0);

    // in_bytes above the word size is clamped to a full word
    push({64'h0, 32'h00000001, 32'hCAFEF00D}, 1'b1, 1'b1, 2'd1);
    send_beat(32'hCAFEF00D, 3'd7, 1'b1, 2'd1);
    wait_block();

    // Short word without in_last ends the message
    push({96'h0, 32'h00000178}, 1'b1, 1'b1, 2'd3);
    send_beat(32'h12345678, 3'd1, 1'b0, 2'd3);
    wait_block();

    repeat (3) @(negedge clk);
    chk("idle_out_valid", ifc.out_valid, 1'b0);
    chk("idle_in_ready",  ifc.in_ready,  1'b1);
    chk("sb_drained",     32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
